// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: access size,
// FSM state encoding and the default geometry/latency.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int DEFAULT_DEPTH   = 512;
    localparam int DEFAULT_LATENCY = 2;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input size_e size);
        case (size)
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            SZ_D:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte mask and lane-shifted data, and load
// extraction with sign/zero extension from an aligned 64-bit word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  wmask,
    output logic [63:0] wlane,
    output logic [63:0] rdata
);
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [63:0] shifted;

    assign lo = {1'b0, offset};
    assign hi = lo + (4'd1 << size);

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign wmask[gi] = (4'(gi) >= lo) && (4'(gi) < hi);
    end

    assign wlane   = wdata << {offset, 3'b000};
    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        rdata = shifted;
        case (size)
            SZ_B: rdata = is_unsigned ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: rdata = is_unsigned ? {48'd0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: rdata = is_unsigned ? {32'd0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
            default: rdata = shifted;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with byte-lane stores and extended loads.
// Define DMEM_ALIGN_CHK_EN to fault misaligned accesses instead of masking them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic       clk,
    input  logic       rst,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_e      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        we_reg;
    logic [63:0] addr_reg;
    size_e       size_reg;
    logic        unsigned_reg;
    logic [63:0] wdata_reg;
    logic        err_reg;
    logic [63:0] word_reg;

    logic [63:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        access_we;
    logic [63:0] access_addr;
    size_e       access_size;
    logic        access_unsigned;
    logic [63:0] access_wdata;
    logic [2:0]  access_offset;
    logic        range_err;
    logic        align_err;
    logic        access_err;
    logic [AW-1:0] mem_idx;
    logic [7:0]  wmask;
    logic [63:0] wlane;
    logic [63:0] load_data;

    assign accept     = (state_reg == ST_IDLE) && bus.req_valid;
    assign enter_resp = (state_reg != ST_RESP) && (state_next == ST_RESP);

    // In IDLE the live request drives the access (LATENCY=1 commits on the
    // accept edge); afterwards the latched copy is used.
    assign access_we       = (state_reg == ST_IDLE) ? bus.req_we             : we_reg;
    assign access_addr     = (state_reg == ST_IDLE) ? bus.req_addr           : addr_reg;
    assign access_size     = (state_reg == ST_IDLE) ? size_e'(bus.req_size)  : size_reg;
    assign access_unsigned = (state_reg == ST_IDLE) ? bus.req_unsigned       : unsigned_reg;
    assign access_wdata    = (state_reg == ST_IDLE) ? bus.req_wdata          : wdata_reg;

    assign access_offset = access_addr[2:0] & ~align_mask(access_size);
    assign range_err     = access_addr[63:3] >= 61'(DEPTH);
`ifdef DMEM_ALIGN_CHK_EN
    assign align_err     = |(access_addr[2:0] & align_mask(access_size));
`else
    assign align_err     = 1'b0;
`endif
    assign access_err    = range_err | align_err;
    assign mem_idx       = access_addr[AW+2:3];

    dmem_lane_align u_align (
        .offset      (access_offset),
        .size        (access_size),
        .is_unsigned (access_unsigned),
        .wdata       (access_wdata),
        .rword       (word_reg),
        .wmask       (wmask),
        .wlane       (wlane),
        .rdata       (load_data)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        count_next = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 4'd0;
            we_reg       <= 1'b0;
            addr_reg     <= 64'd0;
            size_reg     <= SZ_B;
            unsigned_reg <= 1'b0;
            wdata_reg    <= 64'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                we_reg       <= bus.req_we;
                addr_reg     <= bus.req_addr;
                size_reg     <= size_e'(bus.req_size);
                unsigned_reg <= bus.req_unsigned;
                wdata_reg    <= bus.req_wdata;
            end
            if (enter_resp) err_reg <= access_err;
        end
    end

    // Storage is never reset; reads are registered so the array maps to block RAM.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            word_reg <= mem[mem_idx];
            if (access_we && !access_err && !rst) begin
                for (int b = 0; b < 8; b++) begin
                    if (wmask[b]) mem[mem_idx][b*8 +: 8] <= wlane[b*8 +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.rsp_err   = (state_reg == ST_RESP) && err_reg;
    assign bus.rsp_rdata = ((state_reg == ST_RESP) && !err_reg && !we_reg) ? load_data : 64'd0;
endmodule
